// File: rtl/taint_pkg.sv
// Shared types and helpers for the taint flow monitor: state encoding and
// the hit predicate used to decide whether a taint vector touches a watched tag.
package taint_pkg;

  localparam int TAINT_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HIT   = 2'd2
  } mon_state_t;

  // Operands are sized to the default taint width; narrower vectors are zero-extended by the caller.
  function automatic logic taint_hit(input logic [TAINT_W_DEFAULT-1:0] vec,
                                     input logic [TAINT_W_DEFAULT-1:0] mask);
    return |(vec & mask);
  endfunction

endpackage

// File: rtl/taint_sat_counter.sv
// Saturating up-counter with synchronous clear and load-zero.
// It holds at all-ones instead of wrapping.
module taint_sat_counter
  import taint_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load0,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr || load0) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/taint_flow_monitor.sv
// Taint sink monitor: accumulates observed taint tags, and captures the cycle stamp
// and tag set of the first watched-tag hit. It also counts every hit sample.
module taint_flow_monitor
  import taint_pkg::*;
#(
  parameter int TAINT_W = TAINT_W_DEFAULT,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm,
  input  logic               clear,
  input  logic               in_valid,
  input  logic               c,
  input  logic [TAINT_W-1:0] c_t,
  input  logic [TAINT_W-1:0] watch_mask,
  output logic [1:0]         state_o,
  output logic [TAINT_W-1:0] sticky_t,
  output logic               hit,
  output logic [TAINT_W-1:0] hit_tag,
  output logic [CNT_W-1:0]   first_hit_cycle,
  output logic [CNT_W-1:0]   hit_count
);

  mon_state_t       state;
  logic [CNT_W-1:0] cycle_q;
  logic             hit_now;
  logic             active;
  logic             arm_go;
  logic             cyc_inc;
  logic             hit_inc;
  logic             unused_c;

  // The data value is deliberately ignored, so an X on c can never reach state or outputs.
  assign unused_c = c;

  assign hit_now = in_valid && taint_hit(TAINT_W_DEFAULT'(c_t), TAINT_W_DEFAULT'(watch_mask));
  assign active  = (state == ARMED) || (state == HIT);
  assign arm_go  = !clear && (state == IDLE) && arm;
  assign cyc_inc = !clear && (state == ARMED);
  assign hit_inc = !clear && active && hit_now;

  taint_sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .load0 (arm_go),
    .inc   (cyc_inc),
    .q     (cycle_q)
  );

  taint_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .load0 (arm_go),
    .inc   (hit_inc),
    .q     (hit_count)
  );

  // Control FSM and capture registers; clear outranks arming and hit evaluation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      hit             <= 1'b0;
      sticky_t        <= '0;
      hit_tag         <= '0;
      first_hit_cycle <= '0;
    end else if (clear) begin
      state           <= IDLE;
      hit             <= 1'b0;
      sticky_t        <= '0;
      hit_tag         <= '0;
      first_hit_cycle <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            state    <= ARMED;
            sticky_t <= '0;
          end
        end
        ARMED: begin
          if (in_valid) sticky_t <= sticky_t | c_t;
          if (hit_now) begin
            state           <= HIT;
            hit             <= 1'b1;
            hit_tag         <= c_t & watch_mask;
            first_hit_cycle <= cycle_q;
          end
        end
        HIT: begin
          if (in_valid) sticky_t <= sticky_t | c_t;
        end
        default: begin
          state <= IDLE;
          hit   <= 1'b0;
        end
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_taint_flow_monitor.sv
// Scoreboard bench for taint_flow_monitor: the driver queues hand-computed expectations
// after each edge, and a monitor pops and compares them on the following falling edge.
module tb_taint_flow_monitor;

  typedef struct {
    string       name;
    logic [1:0]  st;
    logic [31:0] sticky;
    logic        hit;
    logic [31:0] tag;
    logic [3:0]  fhc;
    logic [3:0]  cnt;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        arm;
  logic        clear;
  logic        in_valid;
  logic        c;
  logic [31:0] c_t;
  logic [31:0] watch_mask;
  logic [1:0]  state_o;
  logic [31:0] sticky_t;
  logic        hit;
  logic [31:0] hit_tag;
  logic [3:0]  first_hit_cycle;
  logic [3:0]  hit_count;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  taint_flow_monitor #(.TAINT_W(32), .CNT_W(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .arm             (arm),
    .clear           (clear),
    .in_valid        (in_valid),
    .c               (c),
    .c_t             (c_t),
    .watch_mask      (watch_mask),
    .state_o         (state_o),
    .sticky_t        (sticky_t),
    .hit             (hit),
    .hit_tag         (hit_tag),
    .first_hit_cycle (first_hit_cycle),
    .hit_count       (hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(string n, logic [1:0] st, logic [31:0] sk, logic h,
                              logic [31:0] tg, logic [3:0] f, logic [3:0] ct);
    exp_t e;
    e.name = n; e.st = st; e.sticky = sk; e.hit = h; e.tag = tg; e.fhc = f; e.cnt = ct;
    return e;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Drive one cycle of inputs, then queue what the outputs must show after the edge.
  task automatic apply_stimulus(input logic a, input logic cl, input logic v, input logic cc,
                                input logic [31:0] ct, input logic [31:0] wm,
                                input bit chk, input exp_t e);
    @(negedge clk);
    arm = a; clear = cl; in_valid = v; c = cc; c_t = ct; watch_mask = wm;
    @(posedge clk);
    #1;
    if (chk) exp_q.push_back(e);
  endtask

  // Monitor: compare every field of the oldest expectation on each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output({e.name, ".state"},  32'(state_o),         32'(e.st));
        check_output({e.name, ".sticky"}, sticky_t,             e.sticky);
        check_output({e.name, ".hit"},    32'(hit),             32'(e.hit));
        check_output({e.name, ".tag"},    hit_tag,              e.tag);
        check_output({e.name, ".fhc"},    32'(first_hit_cycle), 32'(e.fhc));
        check_output({e.name, ".cnt"},    32'(hit_count),       32'(e.cnt));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t z;
    z = mk("none", 2'd0, 32'h0, 1'b0, 32'h0, 4'h0, 4'h0);
    rst_n = 1'b0; arm = 1'b0; clear = 1'b0; in_valid = 1'b0; c = 1'b0;
    c_t = 32'h0; watch_mask = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] reset values");
    apply_stimulus(0, 0, 0, 0, 32'h0, 32'h0, 1, mk("reset", 2'd0, 32'h0, 0, 32'h0, 4'h0, 4'h0));

    $display("[TB] basic hit");
    apply_stimulus(1, 0, 0, 0, 32'h0, 32'h2, 1, mk("b_arm", 2'd1, 32'h0, 0, 32'h0, 4'h0, 4'h0));
    apply_stimulus(0, 0, 1, 0, 32'h1, 32'h2, 1, mk("b_s1",  2'd1, 32'h1, 0, 32'h0, 4'h0, 4'h0));
    apply_stimulus(0, 0, 1, 0, 32'h0, 32'h2, 1, mk("b_s2",  2'd1, 32'h1, 0, 32'h0, 4'h0, 4'h0));
    apply_stimulus(0, 0, 1, 0, 32'h3, 32'h2, 1, mk("b_s3",  2'd2, 32'h3, 1, 32'h2, 4'h2, 4'h1));
    apply_stimulus(0, 0, 1, 0, 32'h0, 32'h2, 1, mk("b_hold", 2'd2, 32'h3, 1, 32'h2, 4'h2, 4'h1));

    $display("[TB] clear beats arm");
    apply_stimulus(1, 1, 1, 0, 32'h2, 32'h2, 1, mk("clr_arm", 2'd0, 32'h0, 0, 32'h0, 4'h0, 4'h0));

    $display("[TB] async reset in HIT");
    apply_stimulus(1, 0, 0, 0, 32'h0, 32'h2, 1, mk("r_arm", 2'd1, 32'h0, 0, 32'h0, 4'h0, 4'h0));
    apply_stimulus(0, 0, 1, 0, 32'h2, 32'h2, 1, mk("r_hit", 2'd2, 32'h2, 1, 32'h2, 4'h0, 4'h1));
    apply_stimulus(0, 0, 0, 0, 32'h0, 32'h2, 0, z);
    #1 rst_n = 1'b0;
    #1 exp_q.push_back(mk("async_rst", 2'd0, 32'h0, 0, 32'h0, 4'h0, 4'h0));
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(0, 0, 0, 0, 32'h0, 32'h2, 1, mk("post_rst", 2'd0, 32'h0, 0, 32'h0, 4'h0, 4'h0));

    $display("[TB] hit sample in arming cycle");
    apply_stimulus(1, 0, 1, 0, 32'h2, 32'h2, 1, mk("arm_hit", 2'd1, 32'h0, 0, 32'h0, 4'h0, 4'h0));
    apply_stimulus(0, 1, 0, 0, 32'h0, 32'h2, 1, mk("clr1", 2'd0, 32'h0, 0, 32'h0, 4'h0, 4'h0));

    $display("[TB] X on data");
    apply_stimulus(1, 0, 0, 0, 32'h0, 32'h1, 1, mk("x_arm", 2'd1, 32'h0, 0, 32'h0, 4'h0, 4'h0));
    apply_stimulus(0, 0, 1, 1'bx, 32'h1, 32'h1, 1, mk("x_s1", 2'd2, 32'h1, 1, 32'h1, 4'h0, 4'h1));
    apply_stimulus(0, 0, 1, 1'bx, 32'h3, 32'h1, 1, mk("x_s2", 2'd2, 32'h3, 1, 32'h1, 4'h0, 4'h2));
    apply_stimulus(0, 1, 0, 0, 32'h0, 32'h1, 1, mk("clr2", 2'd0, 32'h0, 0, 32'h0, 4'h0, 4'h0));

    $display("[TB] invalid hit ignored");
    apply_stimulus(1, 0, 0, 0, 32'h0, 32'h1, 0, z);
    apply_stimulus(0, 0, 0, 0, 32'h1, 32'h1, 1, mk("inv1", 2'd1, 32'h0, 0, 32'h0, 4'h0, 4'h0));
    apply_stimulus(0, 0, 0, 0, 32'h1, 32'h1, 1, mk("inv2", 2'd1, 32'h0, 0, 32'h0, 4'h0, 4'h0));
    apply_stimulus(0, 1, 0, 0, 32'h0, 32'h1, 0, z);

    $display("[TB] empty watch mask");
    apply_stimulus(1, 0, 0, 0, 32'h0, 32'h0, 0, z);
    apply_stimulus(0, 0, 1, 0, 32'hFFFF_FFFF, 32'h0, 1,
                   mk("mask0", 2'd1, 32'hFFFF_FFFF, 0, 32'h0, 4'h0, 4'h0));
    apply_stimulus(0, 1, 0, 0, 32'h0, 32'h0, 0, z);

    $display("[TB] hit counter saturation");
    apply_stimulus(1, 0, 0, 0, 32'h0, 32'h1, 0, z);
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(0, 0, 1, 0, 32'h1, 32'h1, 1,
                     mk("hcnt_sat", 2'd2, 32'h1, 1, 32'h1, 4'h0, (i >= 14) ? 4'hF : 4'(i + 1)));
    end
    apply_stimulus(0, 1, 0, 0, 32'h0, 32'h1, 0, z);

    $display("[TB] cycle counter saturation");
    apply_stimulus(1, 0, 0, 0, 32'h0, 32'h1, 0, z);
    for (int i = 0; i < 20; i++) apply_stimulus(0, 0, 0, 0, 32'h1, 32'h1, 0, z);
    apply_stimulus(0, 0, 1, 0, 32'h1, 32'h1, 1, mk("cyc_sat", 2'd2, 32'h1, 1, 32'h1, 4'hF, 4'h1));

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/taint_flow_monitor.md
# taint_flow_monitor

- Sink stage placed directly downstream of a taint-instrumented combinational gate.
- Each clock cycle it samples the gate's output value and its `TAINT_W`-bit taint vector.
- It accumulates the union of all taint tags observed and detects the first cycle in which any watched tag reaches the output.
- It records the cycle stamp and tag set of that first hit, and counts subsequent tainted samples.

## Interface
Parameters:
- `TAINT_W`, 32, width of the taint vector (one bit per taint source).
- `CNT_W`, 16, width of the cycle and hit counters.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `arm` input 1: start monitoring (level, sampled at clock edge).
- `clear` input 1: synchronous return to IDLE; clears all capture registers.
- `in_valid` input 1: the current `c`/`c_t` sample is meaningful.
- `c` input 1: data output of the upstream gate; may carry X.
- `c_t` input TAINT_W: taint vector of `c`.
- `watch_mask` input TAINT_W: taint bits that constitute a hit.
- `state_o` output 2: current state (IDLE=0, ARMED=1, HIT=2).
- `sticky_t` output TAINT_W: OR of all `c_t` sampled while ARMED or HIT.
- `hit` output 1: high while in HIT.
- `hit_tag` output TAINT_W: `c_t & watch_mask` at the first hit.
- `first_hit_cycle` output CNT_W: cycle counter value at the first hit.
- `hit_count` output CNT_W: number of hit samples, including the first.

## Operation
- States:
  - IDLE: counters frozen; samples ignored.
  - ARMED: samples accumulate; waiting for a hit.
  - HIT: sticky capture; further hits are counted.
- Transitions:
  - IDLE → ARMED when `arm`=1. The same edge loads the cycle counter with 0 and clears `sticky_t`.
  - ARMED → HIT on a sample with `in_valid`=1 and `(c_t & watch_mask) != 0`. That edge also:
    - latches `hit_tag` and `first_hit_cycle` (the counter value before increment);
    - sets `hit_count` to 1.
  - HIT → HIT: each further hit sample increments `hit_count`. `hit_tag` and `first_hit_cycle` never change.
  - Any state → IDLE when `clear`=1. `clear` has priority over `arm` and over a hit in the same cycle.
  - `arm` is ignored in ARMED and HIT; re-arming requires `clear` first.
- Accumulation: while in ARMED or HIT, every `in_valid` sample ORs `c_t` into `sticky_t`, whether or not it is a hit. A hit sample's `c_t` is included.
- Cycle counter: internal, CNT_W wide. Increments every clock in ARMED and saturates at all-ones. `hit_count` also saturates at all-ones.
- X handling: the value of `c` never affects state or outputs. The monitor observes taint only; no X may propagate to any output when `c` is X.
- `watch_mask` = 0 means no hit is ever possible; `sticky_t` still accumulates.

## Timing
- All outputs are registered; every response appears one edge after the sampling edge.
- Reset values: `state_o`=0, `hit`=0, `sticky_t`=0, `hit_tag`=0, `first_hit_cycle`=0, `hit_count`=0.
- Asserting `rst_n`=0 mid-operation clears all state immediately, without waiting for a clock edge.
- Release of `rst_n` is synchronous to the next rising edge.
- Hit detection latency is 1 cycle: `hit`=1 on the edge after the hit sample.
- A hit and `arm` in the same IDLE cycle: the edge only arms; the sample is not evaluated.

## Structure
- Shared package `taint_pkg` contains:
  - `TAINT_W` default;
  - state enum `mon_state_t` {IDLE, ARMED, HIT};
  - function `taint_hit(vec, mask)` returning the reduction OR of `vec & mask`.
- Sub-module `taint_sat_counter`, instantiated twice (cycle counter and hit counter):
  - parameterised by CNT_W;
  - ports: `clk`, `rst_n`, `clr`, `load0`, `inc`, `q`;
  - saturating increment.

## Test plan
- Reset: drive `rst_n`=0 mid-HIT → all outputs 0 without waiting for an edge; after release, `state_o`=0.
- Basic hit:
  - Stimulus: `watch_mask`=32'h2, arm, then samples `c_t`=32'h1, 32'h0, 32'h3, each with `in_valid`=1.
  - Required: `hit` rises after the third sample; `hit_tag`=32'h2; `first_hit_cycle`=2; `sticky_t`=32'h3; `hit_count`=1.
- X data:
  - Stimulus: `c`=1'bx with `c_t`=32'h1, then `c`=1'bx with `c_t`=32'h3; `watch_mask`=32'h1.
  - Required: hit on the first sample; no X on any output; `hit_count`=2.
- Priority:
  - In HIT, `clear`=1 and `arm`=1 together → IDLE, all outputs 0.
  - Hit sample with `in_valid`=0 → ignored.
  - `watch_mask`=0 with `c_t`=32'hFFFFFFFF → `hit` stays 0; `sticky_t`=32'hFFFFFFFF.
- Saturation: with CNT_W=4, keep a hit present for 20 cycles → `hit_count`=4'hF and holds; `first_hit_cycle` unchanged.
